puzzle_timer_ctrl: RTL
======================

Name: puzzle_timer_ctrl

Overview:
Game-level sequencer for the sliding-puzzle countdown timer datapath. It turns player buttons and the solved flag from the board logic into load and enable controls for the countdown, and detects time-out from the countdown's minute/second outputs. Its status outputs drive the HEX/VGA status display and gate the move logic.

Parameters:
LOAD_HOLD, 2, cycles cd_load_n is held low during a load (countdown needs ≥2 to settle both fields)
SYNC_STAGES, 2, synchronizer flops on each button input

Ports:
clk  input  1  system clock (50 MHz)
resetn  input  1  asynchronous active-low reset
start  input  1  level, active-high button (already inverted from KEY); rising edge = start/restart
pause  input  1  level, active-high; rising edge = toggle pause
abort  input  1  level, active-high; rising edge = return to IDLE
solved  input  1  level from board checker, already synchronous to clk
time_sel  input  2  difficulty preset, sampled at load
cd_minute  input  4  countdown minutes (0-9)
cd_second  input  6  countdown seconds (0-59)
cd_load_n  output  1  active-low load to countdown (its reset/load input)
cd_enable  output  1  countdown run enable
cd_minute_in  output  4  preset minutes
cd_second_in  output  6  preset seconds
game_active  output  1  high only in RUNNING; move logic accepts moves only then
time_up  output  1  high in EXPIRED
game_won  output  1  high in WON
state_o  output  3  current state encoding, for debug display

Behaviour:
- Reset (async, resetn=0): state IDLE, synchronizers and edge-detect regs 0, cd_load_n=1, cd_enable=0, cd_minute_in=0, cd_second_in=0, all status outputs 0.
- Button path: SYNC_STAGES-flop sync, then a 1-cycle pulse on a 0→1 transition of the synced level. Holding a button produces one event only. Button-to-event latency is SYNC_STAGES+1 cycles.
- Presets (latched into cd_*_in on the start event):
  - 00 → 1:00
  - 01 → 2:00
  - 10 → 3:30
  - 11 → 5:00
  - cd_*_in is held stable until the next start event.
- States: IDLE=0, LOAD=1, ARM=2, RUNNING=3, PAUSED=4, EXPIRED=5, WON=6.
- IDLE: start event → LOAD.
- LOAD: cd_load_n=0, cd_enable=0 for exactly LOAD_HOLD cycles, then → ARM.
- ARM: one cycle, cd_load_n=1, cd_enable=0. Zero-detect is masked in LOAD and ARM, so a stale 0:00 from a previous game never expires the new game. Then → RUNNING.
- RUNNING: cd_enable=1, game_active=1. Checked in priority order:
  1. solved=1 → WON.
  2. cd_minute==0 && cd_second==0 → EXPIRED.
  3. pause event → PAUSED.
  4. Otherwise stay.
- Priority rule: solved and 0:00 in the same cycle → WON.
- PAUSED: cd_enable=0, game_active=0, countdown value frozen. Pause event → RUNNING. solved is ignored while paused.
- EXPIRED / WON: cd_enable=0, time_up or game_won asserted, countdown value retained for display. Start event → LOAD (new game with current time_sel).
- Abort event in any state except IDLE → IDLE. Abort during LOAD ends the load immediately: cd_load_n=1 on the next edge.
- Simultaneous events: abort beats start and pause; start is ignored in LOAD, ARM, RUNNING and PAUSED.
- Outputs are registered, decoded from the state register. cd_enable changes on the clock edge that enters or leaves RUNNING.
- Reset mid-game: immediate IDLE, with the countdown enable dropped asynchronously.

Decomposition:
- Shared package puzzle_pkg holds:
  - state encodings (ST_IDLE..ST_WON, 3-bit)
  - preset constants (PRESET_MIN/SEC for each time_sel value)
  - MAX_SECOND=59
- One sub-module, btn_edge: synchronizer plus rising-edge pulse, with the SYNC_STAGES parameter. Instantiated three times (start, pause, abort).

Test Plan:
1. Reset, time_sel=10, start pulse → after SYNC_STAGES+1 cycles state=LOAD, cd_load_n low exactly 2 cycles, cd_minute_in=3, cd_second_in=30, then ARM 1 cycle, then RUNNING with cd_enable=1.
2. Bench model holds cd = 0:00 through LOAD/ARM (stale) → no EXPIRED. Then model counts to 0:00 in RUNNING → EXPIRED next cycle, time_up=1, cd_enable=0.
3. RUNNING at 1:15, pause pulse → PAUSED, cd_enable=0. Hold pause high 100 cycles → stays PAUSED. Release and press again → RUNNING.
4. RUNNING, solved=1 and cd=0:00 in the same cycle → WON, game_won=1, time_up=0.
5. Abort asserted in LOAD cycle 1 → IDLE next edge, cd_load_n=1. Start and abort pulses in the same cycle from IDLE → abort has no effect in IDLE; start proceeds to LOAD.
6. resetn asserted mid-RUNNING (not on a clock edge) → outputs go to reset values immediately. After release, start with time_sel=00 → load of 1:00.

Source files
------------

// File: rtl/puzzle_pkg.sv
// Shared definitions for the sliding-puzzle game sequencer: state encodings and
// difficulty presets for the countdown timer.
package puzzle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ARM     = 3'd2,
    ST_RUNNING = 3'd3,
    ST_PAUSED  = 3'd4,
    ST_EXPIRED = 3'd5,
    ST_WON     = 3'd6
  } state_t;

  localparam logic [3:0] PRESET_MIN_0 = 4'd1;
  localparam logic [5:0] PRESET_SEC_0 = 6'd0;
  localparam logic [3:0] PRESET_MIN_1 = 4'd2;
  localparam logic [5:0] PRESET_SEC_1 = 6'd0;
  localparam logic [3:0] PRESET_MIN_2 = 4'd3;
  localparam logic [5:0] PRESET_SEC_2 = 6'd30;
  localparam logic [3:0] PRESET_MIN_3 = 4'd5;
  localparam logic [5:0] PRESET_SEC_3 = 6'd0;

  localparam int unsigned MAX_SECOND = 59;

  function automatic logic [3:0] preset_min(input logic [1:0] sel);
    case (sel)
      2'd0:    return PRESET_MIN_0;
      2'd1:    return PRESET_MIN_1;
      2'd2:    return PRESET_MIN_2;
      default: return PRESET_MIN_3;
    endcase
  endfunction

  function automatic logic [5:0] preset_sec(input logic [1:0] sel);
    case (sel)
      2'd0:    return PRESET_SEC_0;
      2'd1:    return PRESET_SEC_1;
      2'd2:    return PRESET_SEC_2;
      default: return PRESET_SEC_3;
    endcase
  endfunction

endpackage

// File: rtl/puzzle_timer_ctrl_btn_edge.sv
// Button synchronizer followed by a rising-edge detector; a held button yields
// a single one-cycle pulse.
module btn_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= btn_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Combinational pulse keeps button-to-state latency at SYNC_STAGES+1 cycles.
  assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/puzzle_timer_ctrl.sv
// Game-level sequencer: turns buttons and the solved flag into countdown
// load/enable controls and detects time-out from the countdown value.
module puzzle_timer_ctrl
  import puzzle_pkg::*;
#(
  parameter int unsigned LOAD_HOLD   = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic       solved,
  input  logic [1:0] time_sel,
  input  logic [3:0] cd_minute,
  input  logic [5:0] cd_second,
  output logic       cd_load_n,
  output logic       cd_enable,
  output logic [3:0] cd_minute_in,
  output logic [5:0] cd_second_in,
  output logic       game_active,
  output logic       time_up,
  output logic       game_won,
  output logic [2:0] state_o
);

  localparam int unsigned CW = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;

  logic start_ev, pause_ev, abort_ev;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk_i(clk), .rst_ni(resetn), .btn_i(start), .pulse_o(start_ev)
  );
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pause (
    .clk_i(clk), .rst_ni(resetn), .btn_i(pause), .pulse_o(pause_ev)
  );
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_abort (
    .clk_i(clk), .rst_ni(resetn), .btn_i(abort), .pulse_o(abort_ev)
  );

  state_t        state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          latch_preset;
  logic          cd_zero;

  logic       load_n_q, enable_q, active_q, up_q, won_q;
  logic [3:0] min_q;
  logic [5:0] sec_q;

  assign cd_zero = (cd_minute == 4'd0) && (cd_second == 6'd0);

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    latch_preset = 1'b0;
    if (abort_ev && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_EXPIRED, ST_WON: begin
          if (start_ev) begin
            state_d      = ST_LOAD;
            hold_d       = '0;
            latch_preset = 1'b1;
          end
        end
        ST_LOAD: begin
          if (hold_q == CW'(LOAD_HOLD - 1)) state_d = ST_ARM;
          else                              hold_d  = hold_q + 1'b1;
        end
        ST_ARM: state_d = ST_RUNNING;
        ST_RUNNING: begin
          if (solved)        state_d = ST_WON;
          else if (cd_zero)  state_d = ST_EXPIRED;
          else if (pause_ev) state_d = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (pause_ev) state_d = ST_RUNNING;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as state_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      load_n_q <= 1'b1;
      enable_q <= 1'b0;
      active_q <= 1'b0;
      up_q     <= 1'b0;
      won_q    <= 1'b0;
      min_q    <= '0;
      sec_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      load_n_q <= (state_d != ST_LOAD);
      enable_q <= (state_d == ST_RUNNING);
      active_q <= (state_d == ST_RUNNING);
      up_q     <= (state_d == ST_EXPIRED);
      won_q    <= (state_d == ST_WON);
      if (latch_preset) begin
        min_q <= preset_min(time_sel);
        sec_q <= preset_sec(time_sel);
      end
    end
  end

  assign cd_load_n    = load_n_q;
  assign cd_enable    = enable_q;
  assign game_active  = active_q;
  assign time_up      = up_q;
  assign game_won     = won_q;
  assign cd_minute_in = min_q;
  assign cd_second_in = sec_q;
  assign state_o      = state_q;

endmodule
